mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Arbitrates the instruction cache and the data cache for the single shared main-memory line port; services one line transaction at a time.
- Sits between both caches and the memory model.
- Gives the data cache priority because its miss stalls the whole pipe.
- Bounds instruction-cache starvation with a streak counter.
- Aborts hung transactions with a watchdog.

Parameters:
LINE_W, 128, line width in bits for all data buses
ADDR_W, 32, address width
MAX_DC_STREAK, 4, consecutive DC grants allowed while IC waits
TIMEOUT, 255, cycles waited for mem_ready before abort; must be ≥1

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous active-low reset (asserts when 0, released synchronously to clk)
ic_req  input  1  instruction cache line-fill request, held until ic_ready
ic_addr  input  ADDR_W  fill address, stable while ic_req
ic_ready  output  1  one-cycle completion pulse to instruction cache
ic_rdata  output  LINE_W  fill data, valid when ic_ready
dc_req  input  1  data cache request, held until dc_ready
dc_we  input  1  1 = line writeback, 0 = line fill
dc_addr  input  ADDR_W  request address
dc_wdata  input  LINE_W  writeback data
dc_ready  output  1  one-cycle completion pulse to data cache
dc_rdata  output  LINE_W  fill data, valid when dc_ready
mem_req  output  1  memory request, held until mem_ready
mem_we  output  1  memory write
mem_addr  output  ADDR_W  line-aligned address
mem_wdata  output  LINE_W  write data
mem_ready  input  1  memory completion, one-cycle pulse
mem_rdata  input  LINE_W  read data, valid with mem_ready
owner  output  1  0 = IC, 1 = DC; current or last grant
busy  output  1  high in any state other than IDLE
bus_err  output  1  sticky, set on watchdog abort

Behaviour:
- Reset (reset=0): state IDLE; mem_req, mem_we, ic_ready, dc_ready, busy, bus_err = 0; mem_addr, mem_wdata, ic_rdata, dc_rdata = 0; owner = 0; streak counter = 0; timer = 0.
- States: IDLE, GRANT, RESP.
- IDLE, arbitration on every edge:
  - DC wins if dc_req=1 and not (ic_req=1 and streak==MAX_DC_STREAK).
  - Otherwise IC wins if ic_req=1.
  - With neither request, stay in IDLE.
- Winner latching in IDLE: owner, mem_addr (low log2(LINE_W/8) bits forced to 0), mem_we (dc_we for DC, 0 for IC) and mem_wdata (dc_wdata for DC) are latched. Next state is GRANT.
- Streak counter, updated at the arbitration edge:
  - DC grant with ic_req=1: increment, saturating at MAX_DC_STREAK.
  - IC grant: clear to 0.
  - DC grant with ic_req=0: clear to 0.
- GRANT:
  - mem_req=1; mem_addr, mem_we and mem_wdata are held stable; timer increments each cycle.
  - mem_ready=1: latch mem_rdata into the owner's rdata register (writeback latches nothing), clear the timer, go to RESP.
  - Timer reaches TIMEOUT with no mem_ready: set bus_err, drive the owner's rdata to 0, go to RESP.
- RESP:
  - mem_req=0; the owner's ready is high for exactly this cycle.
  - Next state is IDLE with no arbitration in this cycle.
  - Requester drops req on the edge ending the ready cycle. A req still high in IDLE is treated as a new request.
- Latency: request seen in IDLE at edge N gives mem_req high from cycle N+1. mem_ready at edge M gives ready high in cycle M+1, then IDLE in M+2. Minimum round-trip with immediate mem_ready is 3 cycles.
- Data-register hold: ic_rdata and dc_rdata hold their last value outside ready; there are no glitch pulses.
- Simultaneous events:
  - ic_req and dc_req rise in the same cycle: DC wins unless the streak is saturated.
  - mem_ready in the same cycle the timer hits TIMEOUT: mem_ready wins and bus_err is not set.
- Asynchronous reset mid-GRANT: mem_req drops immediately and the transaction is abandoned. Requesters must re-issue after reset.
- bus_err is cleared only by reset.
- Requests arriving while busy are ignored until IDLE; there is no queueing.

Test Plan:
- Single IC fill at 0x0000_1234, mem_ready 2 cycles after mem_req → mem_addr=0x0000_1230, mem_we=0, ic_ready one cycle with ic_rdata=mem_rdata, dc_ready stays 0.
- ic_req and dc_req (dc_we=1, dc_addr=0x80, dc_wdata=0xA5..A5) raised together → DC served first with mem_we=1 and mem_wdata=0xA5..A5; IC served next; owner sequence 1, 0.
- dc_req continuously re-asserted and ic_req held high, MAX_DC_STREAK=4 → exactly 4 DC grants, then 1 IC grant, then DC resumes.
- mem_ready never asserted, TIMEOUT=8 → mem_req high for 8 cycles, then bus_err=1, dc_ready pulse with dc_rdata=0; bus_err remains 1 across later transactions.
- mem_ready on the exact TIMEOUT cycle → normal completion, bus_err=0.
- reset driven to 0 during GRANT → mem_req=0 and busy=0 asynchronously; after release, state is IDLE and a fresh ic_req completes normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// Shared main-memory line-port arbiter between the instruction and data caches.
// DC has priority; a streak counter bounds IC starvation and a watchdog aborts hung transfers.
module mem_arbiter #(
  parameter int LINE_W        = 128,
  parameter int ADDR_W        = 32,
  parameter int MAX_DC_STREAK = 4,
  parameter int TIMEOUT       = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_ready,
  output logic [LINE_W-1:0] ic_rdata,
  input  logic              dc_req,
  input  logic              dc_we,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [LINE_W-1:0] dc_wdata,
  output logic              dc_ready,
  output logic [LINE_W-1:0] dc_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [LINE_W-1:0] mem_rdata,
  output logic              owner,
  output logic              busy,
  output logic              bus_err
);

  // state | meaning
  // IDLE  | arbitrate pending requests, latch the winner
  // GRANT | mem_req held, waiting for mem_ready or watchdog expiry
  // RESP  | one-cycle ready pulse to the owning cache
  typedef enum logic [1:0] {IDLE, GRANT, RESP} state_t;

  localparam int OFFS  = $clog2(LINE_W / 8);
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam int STK_W = $clog2(MAX_DC_STREAK + 1);

  state_t              state_q, state_d;
  logic                owner_q, owner_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                mem_we_q, mem_we_d;
  logic [LINE_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [LINE_W-1:0]   ic_rdata_q, ic_rdata_d;
  logic [LINE_W-1:0]   dc_rdata_q, dc_rdata_d;
  logic [STK_W-1:0]    streak_q, streak_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic                bus_err_q, bus_err_d;

  logic streak_sat, dc_win, ic_win, timer_hit;

  assign streak_sat = (streak_q == STK_W'(MAX_DC_STREAK));
  assign dc_win     = dc_req && !(ic_req && streak_sat);
  assign ic_win     = !dc_win && ic_req;
  // Timer counts completed GRANT cycles, so the last allowed cycle sees TIMEOUT-1.
  assign timer_hit  = (timer_q == TMR_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      ic_rdata_q  <= '0;
      dc_rdata_q  <= '0;
      streak_q    <= '0;
      timer_q     <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      ic_rdata_q  <= ic_rdata_d;
      dc_rdata_q  <= dc_rdata_d;
      streak_q    <= streak_d;
      timer_q     <= timer_d;
      bus_err_q   <= bus_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (dc_win || ic_win) state_d = GRANT;
      GRANT:   if (mem_ready || timer_hit) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    owner_d     = owner_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = mem_we_q;
    mem_wdata_d = mem_wdata_q;
    ic_rdata_d  = ic_rdata_q;
    dc_rdata_d  = dc_rdata_q;
    streak_d    = streak_q;
    timer_d     = timer_q;
    bus_err_d   = bus_err_q;
    case (state_q)
      IDLE: begin
        if (dc_win) begin
          owner_d     = 1'b1;
          mem_addr_d  = {dc_addr[ADDR_W-1:OFFS], {OFFS{1'b0}}};
          mem_we_d    = dc_we;
          mem_wdata_d = dc_wdata;
          timer_d     = '0;
          if (!ic_req)         streak_d = '0;
          else if (!streak_sat) streak_d = streak_q + STK_W'(1);
        end else if (ic_win) begin
          owner_d    = 1'b0;
          mem_addr_d = {ic_addr[ADDR_W-1:OFFS], {OFFS{1'b0}}};
          mem_we_d   = 1'b0;
          timer_d    = '0;
          streak_d   = '0;
        end
      end
      GRANT: begin
        if (mem_ready) begin
          timer_d = '0;
          if (!mem_we_q) begin
            if (owner_q) dc_rdata_d = mem_rdata;
            else         ic_rdata_d = mem_rdata;
          end
        end else if (timer_hit) begin
          timer_d   = '0;
          bus_err_d = 1'b1;
          if (owner_q) dc_rdata_d = '0;
          else         ic_rdata_d = '0;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    mem_req  = (state_q == GRANT);
    busy     = (state_q != IDLE);
    ic_ready = (state_q == RESP) && !owner_q;
    dc_ready = (state_q == RESP) && owner_q;
  end

  assign owner     = owner_q;
  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;
  assign ic_rdata  = ic_rdata_q;
  assign dc_rdata  = dc_rdata_q;
  assign bus_err   = bus_err_q;

endmodule
